// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and MEM stage.
// Optional macro ARB_RR_EN: round-robin tie-break instead of data priority.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_cancel,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } state_e;

    state_e        state_q;
    logic [7:0]    cnt_q;
    logic [7:0]    cnt_d;
    logic          cancel_q;
    logic          i_done_q;
    logic          d_done_q;
    logic          err_q;
    logic          mem_req_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] i_rdata_q;
    logic [DW-1:0] d_rdata_q;
`ifdef ARB_RR_EN
    logic          last_d_q;
`endif

    logic timeout_hit;
    logic cancel_eff;
    logic fetch_ok;
    logic pick_d;
    logic pick_i;

    always_comb begin
        cnt_d       = cnt_q + 8'd1;
        timeout_hit = ({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT);
        cancel_eff  = cancel_q | i_cancel;
        fetch_ok    = i_req & ~i_cancel;
`ifdef ARB_RR_EN
        // On a tie the side that did not win last time goes first
        pick_d      = d_req & (~fetch_ok | ~last_d_q);
`else
        pick_d      = d_req;
`endif
        pick_i      = fetch_ok & ~pick_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cancel_q    <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_RR_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            err_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        cnt_q       <= '0;
`ifdef ARB_RR_EN
                        last_d_q    <= 1'b1;
`endif
                    end else if (pick_i) begin
                        state_q    <= BUSY_I;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= i_addr;
                        cnt_q      <= '0;
                        cancel_q   <= 1'b0;
`ifdef ARB_RR_EN
                        last_d_q   <= 1'b0;
`endif
                    end
                end
                BUSY_I: begin
                    if (!mem_ack) begin
                        cnt_q <= cnt_d;
                    end
                    if (mem_ack || timeout_hit) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        cancel_q  <= 1'b0;
                        err_q     <= ~mem_ack;
                        // A flushed fetch completes on the bus but stays invisible
                        i_done_q  <= ~cancel_eff;
                        if (mem_ack && !cancel_eff) begin
                            i_rdata_q <= mem_rdata;
                        end
                    end else begin
                        cancel_q <= cancel_eff;
                    end
                end
                BUSY_D: begin
                    if (!mem_ack) begin
                        cnt_q <= cnt_d;
                    end
                    if (mem_ack || timeout_hit) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        err_q     <= ~mem_ack;
                        d_done_q  <= 1'b1;
                        if (mem_ack && !mem_we_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_done    = i_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_if  = i_req & ~i_done_q;
    assign stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 15;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic          i_cancel = 1'b0;
    logic          i_done;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(AW),
        .DW(DW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_req(i_req),
        .i_addr(i_addr),
        .i_cancel(i_cancel),
        .i_done(i_done),
        .i_rdata(i_rdata),
        .d_req(d_req),
        .d_we(d_we),
        .d_addr(d_addr),
        .d_wdata(d_wdata),
        .d_done(d_done),
        .d_rdata(d_rdata),
        .stall_if(stall_if),
        .stall_mem(stall_mem),
        .err(err),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Transaction-level model: who owns the port, how long mem_req has been up
    int            owner;      // 0 none, 1 fetch, 2 data
    int            held;       // cycles mem_req has been high
    int            pick;
    bit            cool;       // one idle cycle after every completion
    bit            canc;
    bit            last_data;
    bit            f_ok;
    logic          m_req, m_we, m_id, m_dd, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_ir, m_dr;

    always @(posedge clk) begin
        if (rst) begin
            owner = 0; held = 0; cool = 0; canc = 0; last_data = 0;
            m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_ir = '0; m_dr = '0; m_id = 0; m_dd = 0; m_err = 0;
        end else begin
            m_id = 0; m_dd = 0; m_err = 0;
            if (cool) begin
                cool = 0;
            end else if (owner == 0) begin
                f_ok = i_req && !i_cancel;
                pick = 0;
                if (d_req && f_ok) pick = (RR && last_data) ? 1 : 2;
                else if (d_req) pick = 2;
                else if (f_ok) pick = 1;
                if (pick != 0) begin
                    owner = pick; held = 0; canc = 0; m_req = 1;
                    last_data = (pick == 2);
                    if (pick == 2) begin
                        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                    end else begin
                        m_we = 0; m_addr = i_addr;
                    end
                end
            end else begin
                held++;
                if (owner == 1 && i_cancel) canc = 1;
                if (mem_ack || held == TO) begin
                    m_req = 0; m_err = !mem_ack; cool = 1;
                    if (owner == 1) begin
                        m_id = !canc;
                        if (mem_ack && !canc) m_ir = mem_rdata;
                    end else begin
                        m_dd = 1;
                        if (mem_ack && !m_we) m_dr = mem_rdata;
                    end
                    owner = 0;
                end
            end
        end
    end

    bit chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req", mem_req, m_req);
            check("mem_we", mem_we, m_we);
            check("mem_addr", mem_addr, m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("i_done", i_done, m_id);
            check("i_rdata", i_rdata, m_ir);
            check("d_done", d_done, m_dd);
            check("d_rdata", d_rdata, m_dr);
            check("err", err, m_err);
            check("stall_if", stall_if, i_req & ~m_id);
            check("stall_mem", stall_mem, d_req & ~m_dd);
        end
    end

    // Memory responder: ack a fixed or random number of cycles after mem_req rises
    bit            rand_mode = 0;
    int            ack_delay = 1;
    int            hi = 0;
    int            cur_dly = 0;
    logic [DW-1:0] resp_data = '0;

    always @(negedge clk) begin
        #1;
        if (mem_req === 1'b1) begin
            hi++;
            if (hi == 1) begin
                if (rand_mode)
                    cur_dly = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 5));
                else
                    cur_dly = ack_delay;
            end
            mem_ack = (cur_dly != 0 && hi == cur_dly);
            mem_rdata = rand_mode ? DW'($urandom) : resp_data;
        end else begin
            hi = 0;
            mem_ack = rand_mode && ($urandom_range(0, 3) == 0);
            mem_rdata = DW'($urandom);
        end
    end

    // Random requesters obeying the hold-until-done protocol
    always @(negedge clk) begin
        #1;
        if (rand_mode) begin
            if (i_cancel) begin
                i_cancel = 0;
                i_req = 1'($urandom);
                i_addr = AW'($urandom);
            end else if (!i_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    i_req = 1; i_addr = AW'($urandom);
                end
            end else if (i_done) begin
                i_req = ($urandom_range(0, 3) != 0);
                i_addr = AW'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
                i_cancel = 1;
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1; d_we = 1'($urandom);
                    d_addr = AW'($urandom); d_wdata = DW'($urandom);
                end
            end else if (d_done) begin
                d_req = ($urandom_range(0, 3) != 0);
                d_we = 1'($urandom);
                d_addr = AW'($urandom); d_wdata = DW'($urandom);
            end
        end
    end

    initial begin
        int            cnt, cnt2, phase, gap, nd, last;
        bit            got, prev;
        logic          s_we, s_we2;
        logic [AW-1:0] s_addr, s_addr2;
        logic [DW-1:0] s_wd;

        repeat (2) step();
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_err", err, 0);
        rst = 0;
        chk_en = 1;
        step();

        // Load with BEEF, ack two cycles after mem_req rises
        ack_delay = 2; resp_data = 16'hBEEF;
        d_req = 1; d_we = 0; d_addr = 16'h0123; d_wdata = '0;
        cnt = 0; got = 0; s_we = 1'bx; s_addr = 'x;
        for (int w = 0; w < 20; w++) begin
            step();
            if (mem_req) begin s_we = mem_we; s_addr = mem_addr; end
            if (d_done) begin got = 1; break; end
            if (stall_mem) cnt++;
        end
        check("load_done", got, 1);
        check("load_rdata", d_rdata, 16'hBEEF);
        check("load_we", s_we, 0);
        check("load_addr", s_addr, 16'h0123);
        check("load_stall_cycles", cnt, 2);
        check("load_stall_at_done", stall_mem, 0);
        d_req = 0;
        cnt = 0;
        repeat (4) begin step(); if (d_done) cnt++; end
        check("load_single_done", cnt, 0);

        // Tie: store wins, fetch follows after the response cycle
        ack_delay = 1; resp_data = 16'h5A5A;
        i_req = 1; i_addr = 16'h0200;
        d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'h1234;
        phase = 0; gap = 0; cnt = 0; got = 0;
        s_we = 1'bx; s_wd = 'x; s_addr = 'x; s_we2 = 1'bx; s_addr2 = 'x;
        for (int w = 0; w < 20; w++) begin
            step();
            if (mem_req) begin
                if (phase == 0) begin
                    phase = 1; s_we = mem_we; s_wd = mem_wdata; s_addr = mem_addr;
                end else if (phase == 2) begin
                    phase = 3; s_we2 = mem_we; s_addr2 = mem_addr;
                end
            end else if (phase == 1 || phase == 2) begin
                phase = 2; gap++;
            end
            if (d_done) d_req = 0;
            if (i_done) begin got = 1; break; end
            if (!stall_if) cnt++;
        end
        check("tie_first_we", s_we, 1);
        check("tie_first_wdata", s_wd, 16'h1234);
        check("tie_first_addr", s_addr, 16'h0040);
        check("tie_second_seen", phase, 3);
        check("tie_gap", gap, 2);
        check("tie_second_addr", s_addr2, 16'h0200);
        check("tie_second_we", s_we2, 0);
        check("tie_fetch_done", got, 1);
        check("tie_stall_if", cnt, 0);
        check("tie_i_rdata", i_rdata, 16'h5A5A);
        i_req = 0;
        repeat (2) step();

        // Fetch cancelled while in flight
        ack_delay = 3; resp_data = 16'h0F0F;
        i_req = 1; i_addr = 16'h0300;
        step();
        check("cancel_req_up", mem_req, 1);
        check("cancel_addr", mem_addr, 16'h0300);
        i_cancel = 1;
        step();
        i_cancel = 0; i_req = 0;
        cnt = 0;
        repeat (8) begin step(); if (i_done) cnt++; end
        check("cancel_no_done", cnt, 0);
        check("cancel_rdata_kept", i_rdata, 16'h5A5A);
        check("cancel_req_low", mem_req, 0);
        ack_delay = 1; resp_data = 16'h1111;
        d_req = 1; d_we = 0; d_addr = 16'h0055;
        step();
        check("cancel_then_idle", mem_req, 1);
        for (int w = 0; w < 10; w++) begin
            step();
            if (d_done) break;
        end
        d_req = 0;
        repeat (2) step();

        // Timeout: no ack ever
        ack_delay = 0;
        d_req = 1; d_we = 0; d_addr = 16'h0777;
        cnt = 0; got = 0; s_we = 1'b0;
        for (int w = 0; w < 40; w++) begin
            step();
            if (err) begin got = 1; s_we = d_done; break; end
            if (mem_req) cnt++;
        end
        check("to_req_cycles", cnt, TO);
        check("to_err", got, 1);
        check("to_done_with_err", s_we, 1);
        check("to_rdata_kept", d_rdata, 16'h1111);
        ack_delay = 1;
        step();
        check("to_resp_req", mem_req, 0);
        check("to_err_single", err, 0);
        step();
        check("to_regrant", mem_req, 1);
        for (int w = 0; w < 10; w++) begin
            step();
            if (d_done) break;
        end
        d_req = 0;
        repeat (2) step();

        // Reset in the middle of a data transaction
        ack_delay = 0;
        d_req = 1; d_we = 0; d_addr = 16'h0999;
        repeat (3) step();
        check("rst_busy_req", mem_req, 1);
        rst = 1;
        step();
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_done", d_done, 0);
        check("rst_mid_err", err, 0);
        check("rst_mid_addr", mem_addr, 0);
        rst = 0; d_req = 0;
        repeat (2) step();

        // Back-to-back fetches
        ack_delay = 1; resp_data = 16'hC0DE;
        i_req = 1; i_addr = 16'h1000;
        nd = 0; last = 0; prev = 0;
        for (int w = 0; w < 40; w++) begin
            step();
            if (mem_req && !prev) check("b2b_addr", mem_addr, i_addr);
            prev = mem_req;
            if (i_done) begin
                if (nd > 0) check("b2b_spacing", w - last, 3);
                last = w; nd++;
                i_addr = i_addr + 16'd4;
                if (nd == 4) break;
            end
        end
        check("b2b_count", nd, 4);
        i_req = 0;
        repeat (3) step();

        // Randomized traffic with stray acks, timeouts, cancels and resets
        rand_mode = 1;
        for (int k = 0; k < 4000; k++) begin
            step();
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 0;
        rand_mode = 0;
        step();

        cnt2 = n_chk;
        $display("%0d/%0d checks passed", n_pass, cnt2);
        $finish;
    end

endmodule
